// File: rtl/exu_types_pkg.sv
// Shared EXU types for the sequential divider: request payload, opcodes,
// divider FSM states and small opcode decode helpers.
package exu_types_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [2:0] {
        DIV_NONE = 3'd0,
        DIV_DIV  = 3'd1,
        DIV_DIVU = 3'd2,
        DIV_REM  = 3'd3,
        DIV_REMU = 3'd4
    } riscv_div_op_e;

    typedef struct packed {
        logic [XLEN-1:0] dataA;
        logic [XLEN-1:0] dataB;
        riscv_div_op_e   opcode;
    } alu_div_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } div_seq_state_e;

    function automatic logic div_is_signed(riscv_div_op_e op);
        return (op == DIV_DIV) || (op == DIV_REM);
    endfunction

    function automatic logic div_is_quot(riscv_div_op_e op);
        return (op == DIV_DIV) || (op == DIV_DIVU);
    endfunction

    function automatic logic div_is_arith(riscv_div_op_e op);
        return (op == DIV_DIV) || (op == DIV_DIVU) || (op == DIV_REM) || (op == DIV_REMU);
    endfunction

endpackage

// File: rtl/exu_div_step.sv
// One restoring shift-subtract division step on unsigned magnitudes.
module exu_div_step
    import exu_types_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shl;
    logic [XLEN:0] diff;

    // Bit XLEN of the difference is the borrow: set when the trial subtract fails.
    assign shl   = {rem_i, quo_i[XLEN-1]};
    assign diff  = shl - {1'b0, dvs_i};
    assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
    assign rem_o = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];

endmodule

// File: rtl/exu_div_seq.sv
// Sequential 32-bit RISC-V divider (DIV/DIVU/REM/REMU), one restoring step per cycle.
// Define EXU_DIV_FASTPATH_EN to resolve divide-by-zero and signed overflow in PREP.
module exu_div_seq
    import exu_types_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_div_t        in_req,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    div_seq_state_e         state_q, state_d;
    riscv_div_op_e          op_q, op_d;
    logic [XLEN-1:0]        a_q, a_d;
    logic [XLEN-1:0]        b_q, b_d;
    logic                   sa_q, sa_d;
    logic                   sb_q, sb_d;
    logic [XLEN-1:0]        quo_q, quo_d;
    logic [XLEN-1:0]        rem_q, rem_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]        res_q, res_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;

    logic [XLEN-1:0]        step_rem;
    logic [XLEN-1:0]        step_quo;
    logic [XLEN-1:0]        quo_fix;
    logic [XLEN-1:0]        rem_fix;

    exu_div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (b_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // b_q holds the divisor magnitude after PREP, so a zero test on it still means divide-by-zero.
    assign quo_fix = ((sa_q ^ sb_q) && (b_q != '0)) ? -quo_q : quo_q;
    assign rem_fix = sa_q ? -rem_q : rem_q;

`ifdef EXU_DIV_FASTPATH_EN
    logic ovf_c;
    assign ovf_c = div_is_signed(op_q) && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        res_d       = '0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_req.opcode;
                    a_d     = in_req.dataA;
                    b_d     = in_req.dataB;
                    sa_d    = div_is_signed(in_req.opcode) & in_req.dataA[XLEN-1];
                    sb_d    = div_is_signed(in_req.opcode) & in_req.dataB[XLEN-1];
                    state_d = PREP;
                end
            end
            PREP: begin
                quo_d   = sa_q ? -a_q : a_q;
                b_d     = sb_q ? -b_q : b_q;
                rem_d   = '0;
                cnt_d   = DIV_CNT_W'(DIV_ITERS - 1);
                state_d = ITER;
                if (!div_is_arith(op_q)) begin
                    state_d = DONE;
                end
`ifdef EXU_DIV_FASTPATH_EN
                else if (b_q == '0) begin
                    state_d = DONE;
                    res_d   = div_is_quot(op_q) ? '1 : a_q;
                end else if (ovf_c) begin
                    state_d = DONE;
                    res_d   = div_is_quot(op_q) ? 32'h8000_0000 : '0;
                end
`endif
            end
            ITER: begin
                quo_d = step_quo;
                rem_d = step_rem;
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end else begin
                    cnt_d = cnt_q - DIV_CNT_W'(1);
                end
            end
            FIXUP: begin
                state_d = DONE;
                res_d   = div_is_quot(op_q) ? quo_fix : rem_fix;
            end
            DONE: begin
                res_d = res_q;
                if (out_ready) begin
                    state_d = IDLE;
                    res_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Kill wins over every transition, including a same-cycle handshake.
        if (flush) begin
            state_d = IDLE;
            res_d   = '0;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= DIV_NONE;
            a_q         <= '0;
            b_q         <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_exu_div_seq.sv
// Scoreboard bench for exu_div_seq: reference division model, latency,
// back-pressure, flush and mid-operation reset.
`timescale 1ns/1ps
module tb_exu_div_seq;
    import exu_types_pkg::*;

`ifdef EXU_DIV_FASTPATH_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = 35;
`endif
    localparam int NORMAL_LAT = 35;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    alu_div_t    in_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    exu_div_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_req     (in_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] res;
        int          n;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input riscv_div_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            DIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIV_REMU: return (b == 0) ? a : a % b;
            DIV_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            DIV_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input riscv_div_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (op == DIV_DIV) || (op == DIV_REM);
        if (op == DIV_NONE) return 2;
        if (b == 0) return SPECIAL_LAT;
        if (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return SPECIAL_LAT;
        return NORMAL_LAT;
    endfunction

    // Called just after a rising edge; leaves the bench just after the handshake edge.
    task automatic issue(input string tag, input riscv_div_op_e op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check_eq({tag, "_wait_ready"}, 32'(in_ready), 32'h1);
            return;
        end
        in_valid      = 1'b1;
        in_req.opcode = op;
        in_req.dataA  = a;
        in_req.dataB  = b;
        e.res = model(op, a, b);
        e.n   = cyc;
        e.lat = model_lat(op, a, b);
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Output monitor: result zero when idle, scoreboard compare and latency on acceptance.
    logic seen = 1'b0;
    int   first_cyc = 0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (!out_valid) begin
                check_eq("result_zero_when_invalid", out_result, 32'h0);
            end else if (!seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out_valid", 32'(out_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq(e.tag, out_result, e.res);
                    check_eq({e.tag, "_latency"}, 32'(first_cyc - e.n), 32'(e.lat));
                end
                seen = 1'b0;
            end
        end else begin
            seen = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          t;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_req    = '0;

        idle_cycles(3);
        check_eq("reset_out_valid", 32'(out_valid), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_out_result", out_result, 32'h0);
        rst_n = 1'b1;
        check_eq("in_ready_after_reset", 32'(in_ready), 32'h1);
        idle_cycles(1);

        issue("divu_100_7", DIV_DIVU, 32'd100, 32'd7);
        issue("remu_100_7", DIV_REMU, 32'd100, 32'd7);
        issue("div_neg7_2", DIV_DIV, 32'hFFFF_FFF9, 32'd2);
        issue("rem_neg7_2", DIV_REM, 32'hFFFF_FFF9, 32'd2);
        issue("divu_by_zero", DIV_DIVU, 32'h1234, 32'h0);
        issue("rem_by_zero", DIV_REM, 32'h1234, 32'h0);
        issue("div_by_zero_neg", DIV_DIV, 32'hFFFF_0000, 32'h0);
        issue("remu_by_zero", DIV_REMU, 32'hDEAD_BEEF, 32'h0);
        issue("div_overflow", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue("rem_overflow", DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        issue("divu_no_overflow", DIV_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        issue("div_none", DIV_NONE, 32'h5555_5555, 32'h3);
        issue("div_pos_neg", DIV_DIV, 32'd1000, 32'hFFFF_FFFD);
        issue("rem_neg_neg", DIV_REM, 32'hFFFF_FC18, 32'hFFFF_FFF9);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            issue("rand_op", riscv_div_op_e'(3'(1 + (i % 4))), a, b);
        end

        // Back-pressure: result must hold while out_ready is low.
        t = 0;
        while (!in_ready && t < 200) begin
            idle_cycles(1);
            t++;
        end
        out_ready = 1'b0;
        issue("stall_div", DIV_DIV, 32'hFFFF_F000, 32'd9);
        t = 0;
        while (!out_valid && t < 100) begin
            idle_cycles(1);
            t++;
        end
        check_eq("stall_valid_seen", 32'(out_valid), 32'h1);
        r = out_result;
        for (int i = 0; i < 5; i++) begin
            idle_cycles(1);
            check_eq("stall_result_stable", out_result, r);
            check_eq("stall_valid_held", 32'(out_valid), 32'h1);
            check_eq("stall_in_ready_low", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        idle_cycles(1);
        check_eq("in_ready_after_accept", 32'(in_ready), 32'h1);
        check_eq("valid_drop_after_accept", 32'(out_valid), 32'h0);

        // Flush on the tenth ITER cycle drops the operation.
        issue("flushed_op", DIV_DIVU, 32'd1000, 32'd3);
        idle_cycles(10);
        flush = 1'b1;
        void'(sb.pop_back());
        idle_cycles(1);
        flush = 1'b0;
        check_eq("flush_in_ready", 32'(in_ready), 32'h1);
        check_eq("flush_busy", 32'(busy), 32'h0);
        check_eq("flush_out_valid", 32'(out_valid), 32'h0);
        idle_cycles(40);
        issue("after_flush", DIV_DIVU, 32'd1000, 32'd3);

        // Handshake coinciding with flush is ignored.
        t = 0;
        while (!in_ready && t < 200) begin
            idle_cycles(1);
            t++;
        end
        in_valid      = 1'b1;
        flush         = 1'b1;
        in_req.opcode = DIV_DIVU;
        in_req.dataA  = 32'd5;
        in_req.dataB  = 32'd1;
        idle_cycles(1);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("flush_hs_busy", 32'(busy), 32'h0);
        check_eq("flush_hs_in_ready", 32'(in_ready), 32'h1);
        idle_cycles(40);

        // Reset mid-operation abandons the result.
        issue("reset_mid_op", DIV_REM, 32'h7654_3210, 32'd77);
        idle_cycles(5);
        rst_n = 1'b0;
        void'(sb.pop_back());
        idle_cycles(1);
        check_eq("midrst_out_valid", 32'(out_valid), 32'h0);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        check_eq("midrst_out_result", out_result, 32'h0);
        rst_n = 1'b1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'h1);
        idle_cycles(40);
        issue("after_reset", DIV_REM, 32'h7654_3210, 32'd77);

        t = 0;
        while (sb.size() != 0 && t < 500) begin
            idle_cycles(1);
            t++;
        end
        check_eq("scoreboard_drained", 32'(sb.size()), 32'h0);
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exu_div_seq.md
EXU_DIV_SEQ -- requirements
Module: exu_div_seq

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 SHALL have `clk`  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have `rst_n`  input  1  reset; synchronous, active-low.
REQ-004 SHALL have `flush`  input  1  pipeline kill; abandons any in-flight operation.
REQ-005 SHALL have `in_valid`  input  1  request valid.
REQ-006 SHALL have `in_ready`  output  1  request accepted when `in_valid` && `in_ready`.
REQ-007 SHALL have `in_req`  input  alu_div_t  dataA = dividend, dataB = divisor, opcode = riscv_div_op_e.
REQ-008 SHALL have `out_valid`  output  1  result valid.
REQ-009 SHALL have `out_ready`  input  1  consumer accepts result.
REQ-010 SHALL have `out_result`  output  32  quotient or remainder.
REQ-011 SHALL have `busy`  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, PREP, ITER, FIXUP, DONE.
REQ-013 SHALL assert `in_ready` only in IDLE; no request queueing; one operation in flight.
REQ-014 SHALL, on handshake in cycle N, latch opcode, operands and operand signs, and enter PREP at N+1.
REQ-015 PREP SHALL convert operands to magnitudes for DIV/REM and pass them unchanged for DIVU/REMU, then enter ITER.
REQ-016 ITER SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, using a 6-bit down-counter loaded with 31 that exits ITER at 0.
REQ-017 FIXUP SHALL negate the quotient if the operand signs differ and the divisor ≠ 0.
REQ-018 FIXUP SHALL negate the remainder if the dividend is negative.
REQ-019 FIXUP SHALL select the quotient for DIV/DIVU and the remainder for REM/REMU, and register it as the result.
REQ-020 Normal latency SHALL be: `out_valid` first high at N+35.
REQ-021 DONE SHALL hold `out_valid` high and `out_result` stable until `out_valid` && `out_ready`, then enter IDLE next cycle.
REQ-022 Divide-by-zero SHALL give quotient 0xFFFFFFFF (DIV and DIVU) and remainder = dividend (REM and REMU).
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM) SHALL give quotient 0x80000000 and remainder 0.
REQ-024 Opcode DIV_NONE SHALL be accepted, go PREP→DONE, and return 0 at N+2.
REQ-025 `flush` SHALL have priority over all transitions: next state IDLE, `out_valid` low, result discarded.
REQ-026 A handshake in the same cycle as `flush` SHALL be ignored.
REQ-027 `out_result` SHALL read 0 whenever `out_valid` is low.

Reset
REQ-028 While `rst_n` is low at a clock edge, the FSM SHALL go to IDLE.
REQ-029 Under reset, `out_valid` = 0, `busy` = 0, `out_result` = 0, the counter = 0 and all operand registers = 0.
REQ-030 `in_ready` SHALL be 1 in the first cycle after `rst_n` rises.
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no output.

Configuration
REQ-032 Macro `EXU_DIV_FASTPATH_EN` SHALL select the special-case path.
REQ-033 With `EXU_DIV_FASTPATH_EN` defined, PREP SHALL detect a zero divisor or signed overflow, load the REQ-022/REQ-023 result directly and go to DONE, so `out_valid` is high at N+2.
REQ-034 Without `EXU_DIV_FASTPATH_EN`, those cases SHALL run the full ITER/FIXUP path, and the natural restoring results plus the FIXUP rules SHALL produce identical values at N+35.

Structure
REQ-035 alu_div_t and riscv_div_op_e SHALL be taken from exu_types_pkg.
REQ-036 The FSM state enum (div_seq_state_e) and the constant DIV_ITERS = 32 SHALL be added to exu_types_pkg.
REQ-037 One combinational sub-module, `exu_div_step`, SHALL implement the single restoring step: inputs partial remainder, quotient and divisor; outputs the next partial remainder and quotient.

Verification
REQ-038 DIVU 100/7 → 14 and REMU 100/7 → 2; `out_valid` at N+35.
REQ-039 DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD, and REM of the same operands → 0xFFFFFFFF.
REQ-040 DIVU 0x1234 / 0 → 0xFFFFFFFF and REM 0x1234 / 0 → 0x1234; latency N+2 with the macro, N+35 without.
REQ-041 DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM of the same operands → 0.
REQ-042 Hold `out_ready` low for 5 cycles after `out_valid` → result stable, `in_ready` low throughout, `in_ready` high the cycle after acceptance.
REQ-043 `flush` in ITER cycle 10 → IDLE next cycle, no `out_valid`; a new request then completes correctly.
